// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read side: pointer width, output-buffer
// state encoding and wrap-safe pointer subtraction.
package fifo_pkg;

  // Encoding equals the number of words held by the output buffer.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } outbuf_state_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fifo_rd_outbuf.sv
// Two-entry output buffer (head + skid) for the FIFO read side, tracked by an
// EMPTY/ONE/TWO FSM; words leave strictly in capture order.
module fifo_rd_outbuf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 capture_i,
  input  logic                 pop_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  output logic                 out_valid_o,
  output logic [DATA_SIZE-1:0] out_data_o,
  output logic [1:0]           held_o
);

  outbuf_state_e        state_q, state_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] skid_q, skid_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (capture_i) begin
          state_d = StOne;
          head_d  = wdata_i;
        end
      end
      StOne: begin
        if (capture_i && pop_i) begin
          head_d = wdata_i;
        end else if (capture_i) begin
          state_d = StTwo;
          skid_d  = wdata_i;
        end else if (pop_i) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // Credit logic never captures while two words are held.
        if (pop_i) begin
          state_d = StOne;
          head_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q != StEmpty);
    held_o      = state_q;
  end

  assign out_data_o = head_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: owns rd_ptr, issues RAM reads under a 2-word credit
// limit and streams words out. Optional almost_empty under FIFO_RD_AEMPTY_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_SIZE     = 8,
  parameter  int unsigned ADDR_DEPTH    = 8,
  parameter  int unsigned AEMPTY_THRESH = 2,
  localparam int unsigned PTR_W         = ptr_w(ADDR_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PTR_W:0]       wr_ptr,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  input  logic                 out_ready,
  output logic                 mem_rd_en,
  output logic [PTR_W-1:0]     mem_raddr,
  output logic [PTR_W:0]       rd_ptr,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 fifo_empty,
`ifdef FIFO_RD_AEMPTY_EN
  output logic                 almost_empty,
`endif
  output logic [PTR_W:0]       fifo_count
);

  if (ADDR_DEPTH < 2 || (ADDR_DEPTH & (ADDR_DEPTH - 1)) != 0 ||
      AEMPTY_THRESH > ADDR_DEPTH + 2) begin : g_param_err
    $error("fifo_rd_ctrl: illegal ADDR_DEPTH or AEMPTY_THRESH");
  end

  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           inflight_q, inflight_d;
  logic           pop;
  logic [1:0]     held;
  logic [2:0]     occ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr_q);
  assign fifo_count = (PTR_W + 1)'(ptr_diff(32'(wr_ptr), 32'(rd_ptr_q), PTR_W + 1));

  // Words held or arriving after this edge must stay within the 2-entry buffer.
  always_comb begin
    pop        = out_valid & out_ready;
    occ        = 3'(held) + 3'(inflight_q) - 3'(pop);
    mem_rd_en  = reset_n & ~fifo_empty & (occ < 3'd2);
    rd_ptr_d   = mem_rd_en ? rd_ptr_q + {{PTR_W{1'b0}}, 1'b1} : rd_ptr_q;
    inflight_d = mem_rd_en;
  end

  assign mem_raddr = rd_ptr_q[PTR_W-1:0];
  assign rd_ptr    = rd_ptr_q;

  fifo_rd_outbuf #(
    .DATA_SIZE (DATA_SIZE)
  ) u_outbuf (
    .clk         (clk),
    .reset_n     (reset_n),
    .capture_i   (inflight_q),
    .pop_i       (pop),
    .wdata_i     (mem_rdata),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .held_o      (held)
  );

`ifdef FIFO_RD_AEMPTY_EN
  logic             aempty_q, aempty_d;
  logic [PTR_W+1:0] total;

  always_comb begin
    total    = (PTR_W + 2)'(fifo_count) + (PTR_W + 2)'(held);
    aempty_d = (total <= (PTR_W + 2)'(AEMPTY_THRESH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aempty_q <= 1'b1;
    end else begin
      aempty_q <= aempty_d;
    end
  end

  assign almost_empty = aempty_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed phases plus random streaming,
// compared against a word-count / queue model of the read side.
module tb_fifo_rd_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [PW:0]   wr_ptr = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_ready = 1'b0;
  logic          mem_rd_en;
  logic [PW-1:0] mem_raddr;
  logic [PW:0]   rd_ptr;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          fifo_empty;
  logic [PW:0]   fifo_count;
`ifdef FIFO_RD_AEMPTY_EN
  logic          almost_empty;
`endif

  fifo_rd_ctrl #(
    .DATA_SIZE     (DW),
    .ADDR_DEPTH    (DEPTH),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_ptr       (wr_ptr),
    .mem_rdata    (mem_rdata),
    .out_ready    (out_ready),
    .mem_rd_en    (mem_rd_en),
    .mem_raddr    (mem_raddr),
    .rd_ptr       (rd_ptr),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .fifo_empty   (fifo_empty),
`ifdef FIFO_RD_AEMPTY_EN
    .almost_empty (almost_empty),
`endif
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_raddr];
  end

  int n_assert = 0;
  int n_fail   = 0;
  // Model: words pushed, reads issued, words popped, read issued last cycle.
  int pushed, reads, pops, infl;
  int ae_exp;
  logic [DW-1:0] exp_q[$];
  bit s_pop, s_rd, s_valid;
  logic [DW-1:0] s_data;
  bit wrap_ptr, wrap_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[PW-1:0]] = d;
    exp_q.push_back(d);
    pushed++;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic model_clear();
    pushed = 0; reads = 0; pops = 0; infl = 0; ae_exp = 1;
    exp_q.delete();
  endtask

  // One clock cycle: check at the falling edge, then advance past the rising edge.
  task automatic cyc();
    int held, pop_now;
    bit ev, er;
    @(negedge clk);
    held    = reads - infl - pops;
    ev      = (held > 0);
    pop_now = (ev && out_ready) ? 1 : 0;
    er      = (pushed != reads) && ((held + infl - pop_now) < 2);
    check("out_valid", out_valid, ev);
    check("mem_rd_en", mem_rd_en, er);
    check("fifo_count", fifo_count, pushed - reads);
    check("fifo_empty", fifo_empty, pushed == reads);
    check("rd_ptr", rd_ptr, reads % 16);
    check("mem_raddr", mem_raddr, reads % 8);
`ifdef FIFO_RD_AEMPTY_EN
    check("almost_empty", almost_empty, ae_exp);
`endif
    s_valid = out_valid;
    s_pop   = out_valid && out_ready;
    s_rd    = mem_rd_en;
    s_data  = out_data;
    if (s_pop) begin
      check("pop_has_word", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
    end
    @(posedge clk);
    #1;
    ae_exp = ((pushed - reads + held) <= 2) ? 1 : 0;
    if (s_rd && (reads % 16) == 15) begin
      wrap_ptr = 1;
      check("rd_ptr_wrap", rd_ptr, 0);
    end
    if (s_rd && (reads % 8) == 7) begin
      wrap_addr = 1;
      check("mem_raddr_wrap", mem_raddr, 0);
    end
    if (s_rd) reads++;
    infl = s_rd ? 1 : 0;
    if (s_pop) begin
      pops++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, p0, sent;
    model_clear();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    wr_ptr = 4'd3;
    #1;
    check("rst_rd_en_wr3", mem_rd_en, 0);
    check("rst_count_wr3", fifo_count, 3);
    wr_ptr = 4'd0;
    #1;
    reset_n = 1'b1;
    repeat (2) cyc();

    // Single-word latency.
    out_ready = 1'b1;
    push(8'hA5);
    cyc();
    check("lat_rd_en_N", s_rd, 1);
    check("lat_valid_N", s_valid, 0);
    cyc();
    check("lat_valid_N1", s_valid, 0);
    cyc();
    check("lat_valid_N2", s_valid, 1);
    check("lat_data_N2", s_data, 8'hA5);
    check("lat_rd_ptr", rd_ptr, 1);
    repeat (2) cyc();

    // Full RAM with stalled consumer, then drain at full rate.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    r0 = reads;
    repeat (5) cyc();
    check("full_reads", reads - r0, 2);
    check("full_count", fifo_count, 6);
    check("full_valid", out_valid, 1);
    check("full_head", out_data, 8'h10);
    out_ready = 1'b1;
    p0 = pops;
    repeat (8) cyc();
    check("tput_pops", pops - p0, 8);
    check("drain_empty", fifo_empty, 1);
    check("drain_valid", out_valid, 0);

    // Random stream of 20 words, out_ready toggling, crossing pointer wrap.
    wrap_ptr = 0;
    wrap_addr = 0;
    sent = 0;
    p0 = pops;
    for (int c = 0; c < 400 && (pops - p0) < 20; c++) begin
      out_ready = (c % 2 == 0);
      if (sent < 20 && (pushed - reads) < 8 && $urandom_range(3) != 0) begin
        push(8'($urandom));
        sent++;
      end
      cyc();
    end
    check("stream_pops", pops - p0, 20);
    check("stream_q_empty", exp_q.size(), 0);
    check("stream_wrap_ptr", wrap_ptr, 1);
    check("stream_wrap_addr", wrap_addr, 1);

    // Reset while the buffer holds two words.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    repeat (3) cyc();
    check("pre_rst_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("rst2_valid", out_valid, 0);
    check("rst2_rd_ptr", rd_ptr, 0);
    check("rst2_rd_en", mem_rd_en, 0);
    check("rst2_count", fifo_count, pushed % 16);
    model_clear();
    wr_ptr = '0;
    #1;
    check("rst2_empty", fifo_empty, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    push(8'h3C);
    repeat (4) cyc();
    check("post_rst_pops", pops, 1);
    check("post_rst_rd_ptr", rd_ptr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
